// File: rtl/vga_timing_pkg.sv
// Shared VGA raster constants: default 640x480@60 timing, raster-size helpers
// and sync polarity. The sync pulses on this raster are active-low.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF   = 640;
    localparam int H_FP_DEF       = 16;
    localparam int H_SYNC_DEF     = 96;
    localparam int H_BP_DEF       = 48;
    localparam int V_ACTIVE_DEF   = 480;
    localparam int V_FP_DEF       = 10;
    localparam int V_SYNC_DEF     = 2;
    localparam int V_BP_DEF       = 33;
    localparam int PIPE_DELAY_DEF = 2;

    // Counters are 10 bits wide, so neither raster dimension may exceed this.
    localparam int MAX_TOTAL      = 1024;
    localparam int MAX_PIPE_DELAY = 4;

    localparam logic SYNC_ASSERT = 1'b0;
    localparam logic SYNC_IDLE   = 1'b1;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register that re-times hs/vs/blank to match the pixel
// pipeline latency of the renderers. Each bit has its own reset value.
module vga_sync_delay #(
    parameter int               DEPTH     = 2,
    parameter int               WIDTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= RESET_VAL;
            end
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counter with registered sync/blank decode, pipeline-aligned
// delayed syncs, and line/frame strobes for game logic.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        hs_d,
    output logic        vs_d,
    output logic        blank_d,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_size
        $error("vga_timing_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed 10-bit counters", H_TOTAL, V_TOTAL);
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > MAX_PIPE_DELAY) begin : g_bad_pipe
        $error("vga_timing_gen: PIPE_DELAY=%0d outside 0..%0d", PIPE_DELAY, MAX_PIPE_DELAY);
    end

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  x_q, y_q, x_next, y_next;
    logic        blank_q, hs_q, vs_q, line_start_q, frame_start_q;
    logic        blank_next, hs_next, vs_next, line_next, frame_next;
    logic [15:0] fc_q;

    always_comb begin
        x_next = x_q + 10'd1;
        y_next = y_q;
        if (x_q == H_LAST) begin
            x_next = '0;
            y_next = (y_q == V_LAST) ? '0 : y_q + 10'd1;
        end
    end

    // Decode the next position so the flags land on the same edge as the counters.
    always_comb begin
        blank_next = (x_next < H_ACT) && (y_next < V_ACT);
        hs_next    = ((x_next >= HS_BEGIN) && (x_next < HS_END)) ? SYNC_ASSERT : SYNC_IDLE;
        vs_next    = ((y_next >= VS_BEGIN) && (y_next < VS_END)) ? SYNC_ASSERT : SYNC_IDLE;
        line_next  = (x_next == '0);
        frame_next = line_next && (y_next == '0);
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q           <= '0;
            y_q           <= '0;
            blank_q       <= 1'b0;
            hs_q          <= SYNC_IDLE;
            vs_q          <= SYNC_IDLE;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            fc_q          <= '0;
        end else begin
            x_q           <= x_next;
            y_q           <= y_next;
            blank_q       <= blank_next;
            hs_q          <= hs_next;
            vs_q          <= vs_next;
            line_start_q  <= line_next;
            frame_start_q <= frame_next;
            if (frame_next) begin
                fc_q <= fc_q + 16'd1;
            end
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign blank       = blank_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = fc_q;

    if (PIPE_DELAY == 0) begin : g_no_delay
        assign {hs_d, vs_d, blank_d} = {hs_q, vs_q, blank_q};
    end else begin : g_delay
        vga_sync_delay #(
            .DEPTH     (PIPE_DELAY),
            .WIDTH     (3),
            .RESET_VAL ({SYNC_IDLE, SYNC_IDLE, 1'b0})
        ) u_sync_delay (
            .clk   (vga_clk),
            .rst_n (reset_n),
            .din   ({hs_q, vs_q, blank_q}),
            .dout  ({hs_d, vs_d, blank_d})
        );
    end

endmodule
